// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N producer channels, one
// registered consumer port, plus the forced-select controls.
interface rr_arb_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    force_en;
  logic [CH_W-1:0]         force_sel;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, force_en,
    output force_sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, force_en,
    input  force_sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N:1 arbitrating mux, round-robin by default,
// with a forced-select mode acting as a plain registered mux.
module rr_arb_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int NP   = 2**CH_W;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH-1);

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  ptr_nxt;
  logic [CH_W-1:0]  gnt;
  logic             gnt_vld;
  logic             slot_free;
  logic             take;
  logic [NP-1:0]    vld;
  logic [CH_W:0]    idx;
  logic [WIDTH-1:0] sel_data;
  logic [NUM_CH-1:0] rdy;

  logic [WIDTH-1:0] data_q;
  logic [CH_W-1:0]  ch_q;
  logic             vld_q;

  // Padding keeps out-of-range indices reading as not-valid.
  assign vld       = NP'(bus.in_valid);
  assign slot_free = !vld_q || bus.out_ready;
  assign take      = slot_free && gnt_vld && rst_n;
  assign ptr_nxt   = (gnt == LAST) ? '0 : gnt + 1'b1;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (bus.force_en) begin
      if ({1'b0, bus.force_sel} < NCH &&
          vld[bus.force_sel]) begin
        gnt_vld = 1'b1;
        gnt     = bus.force_sel;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = {1'b0, ptr} + (CH_W+1)'(k);
        if (idx >= NCH) idx = idx - NCH;
        if (!gnt_vld && vld[idx[CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = idx[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    rdy      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == CH_W'(i)) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
        rdy[i]   = take;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr    <= '0;
    end else if (slot_free) begin
      vld_q <= gnt_vld;
      if (gnt_vld) begin
        data_q <= sel_data;
        ch_q   <= gnt;
        if (!bus.force_en) ptr <= ptr_nxt;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = vld_q;
endmodule
